// File: rtl/uart_pkg.sv
// Shared UART definitions: Tx-arbiter FSM encoding and defaults reused by the UART tests.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAITB = 2'd2,
    S_WAITD = 2'd3
  } tx_state_e;

  localparam int UART_DATA_WIDTH   = 8;
  localparam int UART_BUSY_TIMEOUT = 64;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: lowest request at or above ptr, else lowest overall.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_idx,
  output logic               gnt_vld
);

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pick;

  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
    // Fall back to the unmasked vector when nothing sits at or above the pointer (wrap).
    pick    = (|masked) ? masked : req;
    gnt     = pick & (~pick + 1'b1);
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = gnt_idx | IDW'(i);
    end
    gnt_vld = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources, round-robin, one frame at a time.
// Registered outputs; busy watchdog aborts a frame whose Tx never reports busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int INPUT_DATA_WIDTH = UART_DATA_WIDTH,
  parameter int BUSY_TIMEOUT     = UART_BUSY_TIMEOUT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                  ack,
  output logic                                tx_enable,
  output logic [INPUT_DATA_WIDTH-1:0]         tx_data,
  input  logic                                tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id,
  output logic                                timeout_err,
  output logic                                idle
);

  localparam int W   = INPUT_DATA_WIDTH;
  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(BUSY_TIMEOUT);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
  localparam logic [WDW-1:0] WD_LIM  = WDW'(BUSY_TIMEOUT - 1);

  tx_state_e          state_q, state_d;
  logic [IDW-1:0]     rr_q, rr_d, grant_id_d, rr_next;
  logic [WDW-1:0]     wd_q, wd_d;
  logic [NUM_REQ-1:0] ack_d, arb_req, arb_gnt;
  logic [IDW-1:0]     arb_idx;
  logic               arb_vld;
  logic [W-1:0]       sel_data, tx_data_d;
  logic               timeout_d;

  // The requester being acked still shows req this cycle; keep it from being granted twice.
  assign arb_req = req & ~ack;
  assign rr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (arb_req),
    .ptr     (rr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_data = sel_data | req_data[i*W +: W];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    wd_d       = wd_q;
    grant_id_d = grant_id;
    tx_data_d  = tx_data;
    timeout_d  = timeout_err;
    ack_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_vld && !tx_busy) begin
          tx_data_d  = sel_data;
          grant_id_d = arb_idx;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAITB;
      end
      S_WAITB: begin
        if (tx_busy) begin
          state_d = S_WAITD;
        end else if (wd_q == WD_LIM) begin
          timeout_d = 1'b1;
          rr_d      = rr_next;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_WAITD: begin
        if (!tx_busy) begin
          ack_d[grant_id] = 1'b1;
          rr_d            = rr_next;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      wd_q        <= '0;
      grant_id    <= '0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
      ack         <= '0;
      tx_enable   <= 1'b0;
      idle        <= 1'b1;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      wd_q        <= wd_d;
      grant_id    <= grant_id_d;
      tx_data     <= tx_data_d;
      timeout_err <= timeout_d;
      ack         <= ack_d;
      // Registered pulse: the Tx sees enable in the cycle following S_ISSUE, exactly once.
      tx_enable   <= (state_q == S_ISSUE);
      idle        <= (state_d == S_IDLE);
    end
  end

endmodule
